// File: rtl/pim_cmd_scheduler.sv
// pim_cmd_scheduler
//
// Queues PIM commands from the memory-mapped front end and issues them one at
// a time to the eFlash PIM datapath. Each command is strobed to the row driver
// with pim_en_o, the scheduler then waits for the driver's completion pulse
// (or times out), and read/compute commands are followed by a 32-word
// output-buffer load sequence. Commands never overlap.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  command push handshake (ready = FIFO not full)
//   cmd_mode_i           1=program 2=erase 3=read 4=compute, others illegal
//   cmd_row_i/col_i      command row/column address
//   cmd_exec_i           command execution count
//   pim_en_o             one-cycle issue strobe to the row driver
//   pim_mode_o           mode of the active command
//   exec_cnt_o           exec count of the active command
//   row_addr7_o          active row
//   col_addr9_o          active column
//   drv_done_i           row-driver completion pulse
//   load_en_o/load_cnt_o output-buffer load strobe and word index 0..31
//   busy_o               scheduler not idle
//   done_o               one-cycle pulse at command completion
//   err_o/err_clr_i      sticky error flag (illegal mode or timeout) and clear
//   level_o              FIFO occupancy

module pim_cmd_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [2:0]             cmd_mode_i,
    input  logic [6:0]             cmd_row_i,
    input  logic [8:0]             cmd_col_i,
    input  logic [3:0]             cmd_exec_i,
    output logic                   pim_en_o,
    output logic [2:0]             pim_mode_o,
    output logic [3:0]             exec_cnt_o,
    output logic [6:0]             row_addr7_o,
    output logic [8:0]             col_addr9_o,
    input  logic                   drv_done_i,
    output logic                   load_en_o,
    output logic [4:0]             load_cnt_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    input  logic                   err_clr_i,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [PtrW:0]   FullLevel = (PtrW + 1)'(DEPTH);
    localparam logic [TmoW-1:0] TmoLimit  = TmoW'(TIMEOUT);
    localparam logic [4:0]      LastWord  = 5'd31;

    typedef struct packed {
        logic [2:0] mode;
        logic [6:0] row;
        logic [8:0] col;
        logic [3:0] exec;
    } cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StLoad,
        StDone
    } state_e;

    state_e state;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    cmd_t            fifo_mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW:0]   level;
    cmd_t            cmd_in;
    cmd_t            head;
    logic            push;
    logic            pop;
    logic            head_legal;

    assign cmd_in      = '{mode: cmd_mode_i, row: cmd_row_i, col: cmd_col_i, exec: cmd_exec_i};
    assign cmd_ready_o = (level < FullLevel);
    assign push        = cmd_valid_i & cmd_ready_o;
    // The FSM only consumes the head while idle, so at most one pop per command.
    assign pop         = (state == StIdle) && (level != '0);
    assign head        = fifo_mem[rd_ptr];
    assign head_legal  = (head.mode >= 3'd1) && (head.mode <= 3'd4);
    assign level_o     = level;

    // Storage needs no reset: entries are only read while counted in level.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Command sequencing
    // ------------------------------------------------------------------------
    logic [TmoW-1:0] tmo_cnt;
    logic            tmo_hit;
    logic            load_mode;
    logic            err_set;

    // A completion pulse on the timeout edge takes precedence over the abort.
    assign tmo_hit   = (state == StWait) && !drv_done_i && (tmo_cnt == TmoLimit);
    assign load_mode = (pim_mode_o == 3'd3) || (pim_mode_o == 3'd4);
    assign err_set   = (pop && !head_legal) || tmo_hit;
    assign busy_o    = (state != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= StIdle;
            pim_en_o    <= 1'b0;
            pim_mode_o  <= '0;
            exec_cnt_o  <= '0;
            row_addr7_o <= '0;
            col_addr9_o <= '0;
            load_en_o   <= 1'b0;
            load_cnt_o  <= '0;
            done_o      <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            pim_en_o <= 1'b0;
            done_o   <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Illegal entries are popped and dropped; the outputs keep
                    // the previous command's fields.
                    if (pop && head_legal) begin
                        pim_mode_o  <= head.mode;
                        exec_cnt_o  <= head.exec;
                        row_addr7_o <= head.row;
                        col_addr9_o <= head.col;
                        pim_en_o    <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    tmo_cnt <= '0;
                    state   <= StWait;
                end
                StWait: begin
                    if (drv_done_i) begin
                        if (load_mode) begin
                            load_en_o  <= 1'b1;
                            load_cnt_o <= '0;
                            state      <= StLoad;
                        end else begin
                            done_o <= 1'b1;
                            state  <= StDone;
                        end
                    end else if (tmo_hit) begin
                        state <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StLoad: begin
                    if (load_cnt_o == LastWord) begin
                        load_en_o  <= 1'b0;
                        load_cnt_o <= '0;
                        done_o     <= 1'b1;
                        state      <= StDone;
                    end else begin
                        load_cnt_o <= load_cnt_o + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Sticky error: a new error on the same edge as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (err_set) begin
            err_o <= 1'b1;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pim_cmd_scheduler.sv
// Self-checking bench for pim_cmd_scheduler. A command-level reference model
// (queue of pending commands plus the position of the cycle within the active
// command) predicts every output each cycle; directed scenarios add literal
// expectations on latencies, counts and issue order.

module tb_pim_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 1023;

    typedef struct packed {
        logic [2:0] mode;
        logic [6:0] row;
        logic [8:0] col;
        logic [3:0] exec;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_mode = '0;
    logic [6:0] cmd_row = '0;
    logic [8:0] cmd_col = '0;
    logic [3:0] cmd_exec = '0;
    logic       drv_done = 1'b0;
    logic       err_clr = 1'b0;

    logic       cmd_ready_o;
    logic       pim_en_o;
    logic [2:0] pim_mode_o;
    logic [3:0] exec_cnt_o;
    logic [6:0] row_addr7_o;
    logic [8:0] col_addr9_o;
    logic       load_en_o;
    logic [4:0] load_cnt_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [2:0] level_o;

    always #5 clk = ~clk;

    pim_cmd_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_mode_i  (cmd_mode),
        .cmd_row_i   (cmd_row),
        .cmd_col_i   (cmd_col),
        .cmd_exec_i  (cmd_exec),
        .pim_en_o    (pim_en_o),
        .pim_mode_o  (pim_mode_o),
        .exec_cnt_o  (exec_cnt_o),
        .row_addr7_o (row_addr7_o),
        .col_addr9_o (col_addr9_o),
        .drv_done_i  (drv_done),
        .load_en_o   (load_en_o),
        .load_cnt_o  (load_cnt_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr),
        .level_o     (level_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: m_t is the cycle index within the active command (0 is
    // the issue cycle), m_dat the index of the cycle that saw drv_done.
    // ------------------------------------------------------------------------
    cmd_t mq[$];
    bit   m_active = 1'b0;
    int   m_t = 0;
    int   m_dat = -1;
    cmd_t m_cur = '0;
    bit   m_err = 1'b0;

    function automatic int load_len(input logic [2:0] m);
        return (m == 3'd3 || m == 3'd4) ? 32 : 0;
    endfunction

    task automatic model_step();
        bit   do_push;
        bit   eset;
        cmd_t c;
        cmd_t nc;
        int   len;
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0;
            m_t = 0;
            m_dat = -1;
            m_err = 1'b0;
            return;
        end
        do_push = cmd_valid && (mq.size() < DEPTH);
        eset = 1'b0;
        if (!m_active) begin
            if (mq.size() != 0) begin
                c = mq.pop_front();
                if (c.mode >= 3'd1 && c.mode <= 3'd4) begin
                    m_active = 1'b1;
                    m_t = 0;
                    m_dat = -1;
                    m_cur = c;
                end else begin
                    eset = 1'b1;
                end
            end
        end else begin
            len = load_len(m_cur.mode);
            if (m_t >= 1 && m_dat < 0) begin
                if (drv_done) begin
                    m_dat = m_t;
                    m_t++;
                end else if (m_t - 1 == TMO) begin
                    m_active = 1'b0;
                    eset = 1'b1;
                end else begin
                    m_t++;
                end
            end else if (m_dat >= 0 && m_t == m_dat + len + 1) begin
                m_active = 1'b0;
            end else begin
                m_t++;
            end
        end
        if (do_push) begin
            nc.mode = cmd_mode;
            nc.row  = cmd_row;
            nc.col  = cmd_col;
            nc.exec = cmd_exec;
            mq.push_back(nc);
        end
        if (eset) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    task automatic cmp_outputs();
        int len;
        bit e_pen, e_done, e_load;
        int e_lc;
        len    = load_len(m_cur.mode);
        e_pen  = m_active && (m_t == 0);
        e_done = m_active && (m_dat >= 0) && (m_t == m_dat + len + 1);
        e_load = m_active && (m_dat >= 0) && (m_t > m_dat) && (m_t <= m_dat + len);
        e_lc   = e_load ? (m_t - m_dat - 1) : 0;
        chk("busy", int'(busy_o), int'(m_active));
        chk("pim_en", int'(pim_en_o), int'(e_pen));
        chk("done", int'(done_o), int'(e_done));
        chk("load_en", int'(load_en_o), int'(e_load));
        chk("load_cnt", int'(load_cnt_o), e_lc);
        chk("level", int'(level_o), mq.size());
        chk("cmd_ready", int'(cmd_ready_o), int'(mq.size() < DEPTH));
        chk("err", int'(err_o), int'(m_err));
        if (m_active) begin
            chk("pim_mode", int'(pim_mode_o), int'(m_cur.mode));
            chk("exec_cnt", int'(exec_cnt_o), int'(m_cur.exec));
            chk("row_addr", int'(row_addr7_o), int'(m_cur.row));
            chk("col_addr", int'(col_addr9_o), int'(m_cur.col));
        end
    endtask

    // Event log used by the literal expectations of the directed scenarios.
    int pen_count = 0, done_count = 0, load_count = 0, err_rise = 0, full_cnt = 0, over_cnt = 0;
    int pen_cyc = 0, done_cyc = 0, first_load_cyc = 0, err_cyc = 0;
    int last_row = 0, last_col = 0, last_exec = 0;
    int issued_rows[$];
    bit prev_err = 1'b0;

    task automatic monitor();
        if (pim_en_o) begin
            pen_count++;
            pen_cyc = cyc;
            last_row = int'(row_addr7_o);
            last_col = int'(col_addr9_o);
            last_exec = int'(exec_cnt_o);
            issued_rows.push_back(int'(row_addr7_o));
        end
        if (done_o) begin
            done_count++;
            done_cyc = cyc;
        end
        if (load_en_o) begin
            load_count++;
            if (load_cnt_o == 5'd0) first_load_cyc = cyc;
        end
        if (err_o && !prev_err) begin
            err_rise++;
            err_cyc = cyc;
        end
        prev_err = err_o;
        if (level_o == 3'd4 && !cmd_ready_o) full_cnt++;
        if (level_o > 3'd4) over_cnt++;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        cmp_outputs();
        monitor();
    end

    // Row-driver responder: drv_done pulses done_delay cycles after pim_en_o
    // (never when done_delay <= 0); stray pulses are requested via stray_req.
    int done_delay = -1;
    int cd = 0;
    bit cd_act = 1'b0;
    int stray_req = 0;
    int stray_seen = 0;

    always @(negedge clk) begin
        drv_done = 1'b0;
        if (stray_req != stray_seen) begin
            drv_done = 1'b1;
            stray_seen = stray_req;
        end
        if (cd_act) begin
            if (cd == 0) begin
                drv_done = 1'b1;
                cd_act = 1'b0;
            end else begin
                cd--;
            end
        end
        if (pim_en_o && done_delay > 0) begin
            cd = done_delay - 1;
            cd_act = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    int push_cyc = 0;

    task automatic push_cmd(input logic [2:0] m, input logic [6:0] r, input logic [8:0] c,
                            input logic [3:0] e);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode = m;
        cmd_row = r;
        cmd_col = c;
        cmd_exec = e;
        guard = 0;
        while (!cmd_ready_o && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("push_ready", int'(cmd_ready_o), 1);
        @(posedge clk);
        #1;
        push_cyc = cyc;
    endtask

    task automatic end_push();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_done(input string name, input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(done_count >= target && !busy_o) && n < 5000);
        chk({name, "_done_count"}, done_count, target);
        chk({name, "_busy_after"}, int'(busy_o), 0);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_cmd_ready"}, int'(cmd_ready_o), 1);
        chk({p, "_level"}, int'(level_o), 0);
        chk({p, "_pim_en"}, int'(pim_en_o), 0);
        chk({p, "_pim_mode"}, int'(pim_mode_o), 0);
        chk({p, "_exec_cnt"}, int'(exec_cnt_o), 0);
        chk({p, "_row"}, int'(row_addr7_o), 0);
        chk({p, "_col"}, int'(col_addr9_o), 0);
        chk({p, "_load_en"}, int'(load_en_o), 0);
        chk({p, "_load_cnt"}, int'(load_cnt_o), 0);
        chk({p, "_busy"}, int'(busy_o), 0);
        chk({p, "_done"}, int'(done_o), 0);
        chk({p, "_err"}, int'(err_o), 0);
    endtask

    int b_pen, b_done, b_load, b_err, b_full, n, sz;

    initial begin
        // Reset
        wait_cycles(3);
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: single program command, drv_done 3 cycles after issue
        done_delay = 3;
        b_pen = pen_count; b_done = done_count; b_load = load_count;
        push_cmd(3'd1, 7'd5, 9'd9, 4'd2);
        end_push();
        wait_done("t1", b_done + 1);
        chk("t1_issue_count", pen_count - b_pen, 1);
        chk("t1_latency", pen_cyc - push_cyc, 1);
        chk("t1_occupancy", done_cyc - pen_cyc, 4);
        chk("t1_row", last_row, 5);
        chk("t1_col", last_col, 9);
        chk("t1_exec", last_exec, 2);
        chk("t1_no_load", load_count - b_load, 0);

        // 2: compute command, drv_done in the first WAIT cycle
        done_delay = 1;
        b_pen = pen_count; b_done = done_count; b_load = load_count;
        push_cmd(3'd4, 7'd17, 9'd300, 4'd7);
        end_push();
        wait_done("t2", b_done + 1);
        chk("t2_load_cycles", load_count - b_load, 32);
        chk("t2_first_load", first_load_cyc - pen_cyc, 2);
        chk("t2_occupancy", done_cyc - pen_cyc, 34);
        chk("t2_row", last_row, 17);

        // 3: five commands, the last four pushed while the first is in WAIT
        done_delay = 10;
        b_pen = pen_count; b_done = done_count; b_full = full_cnt;
        push_cmd(3'd1, 7'd11, 9'd1, 4'd1);
        end_push();
        n = 0;
        while (pen_count == b_pen && n < 100) begin
            wait_cycles(1);
            n++;
        end
        push_cmd(3'd2, 7'd12, 9'd2, 4'd2);
        push_cmd(3'd1, 7'd13, 9'd3, 4'd3);
        push_cmd(3'd2, 7'd14, 9'd4, 4'd4);
        push_cmd(3'd1, 7'd15, 9'd5, 4'd5);
        end_push();
        wait_done("t3", b_done + 5);
        chk("t3_full_seen", int'(full_cnt > b_full), 1);
        chk("t3_never_over", over_cnt, 0);
        chk("t3_issue_count", pen_count - b_pen, 5);
        sz = issued_rows.size();
        for (int i = 0; i < 5; i++) begin
            chk("t3_order", issued_rows[sz - 5 + i], 11 + i);
        end
        chk("t3_level_end", int'(level_o), 0);

        // 4: withheld completion times out, the queued command still runs
        done_delay = -1;
        b_pen = pen_count; b_done = done_count; b_err = err_rise;
        push_cmd(3'd1, 7'd20, 9'd1, 4'd1);
        push_cmd(3'd2, 7'd21, 9'd2, 4'd2);
        end_push();
        n = 0;
        while (err_rise == b_err && n < 1500) begin
            wait_cycles(1);
            n++;
        end
        chk("t4_err_rise", err_rise - b_err, 1);
        chk("t4_timeout_delay", err_cyc - pen_cyc, TMO + 2);
        done_delay = 2;
        wait_done("t4", b_done + 1);
        chk("t4_issue_count", pen_count - b_pen, 2);
        chk("t4_row", last_row, 21);
        chk("t4_err_sticky", int'(err_o), 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_err_cleared", int'(err_o), 0);

        // Stray completion pulse while idle has no effect
        b_pen = pen_count;
        stray_req++;
        wait_cycles(4);
        chk("stray_no_issue", pen_count - b_pen, 0);

        // 5: illegal mode between two legal commands
        done_delay = 1;
        b_pen = pen_count; b_done = done_count; b_err = err_rise;
        push_cmd(3'd3, 7'd30, 9'd3, 4'd3);
        push_cmd(3'd6, 7'd31, 9'd4, 4'd4);
        push_cmd(3'd2, 7'd32, 9'd5, 4'd5);
        end_push();
        wait_done("t5", b_done + 2);
        chk("t5_issue_count", pen_count - b_pen, 2);
        chk("t5_err", int'(err_o), 1);
        chk("t5_err_rise", err_rise - b_err, 1);
        sz = issued_rows.size();
        chk("t5_first_row", issued_rows[sz - 2], 30);
        chk("t5_second_row", issued_rows[sz - 1], 32);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // 6: error set wins over a clear held on the same edge
        b_pen = pen_count; b_err = err_rise;
        @(negedge clk);
        err_clr = 1'b1;
        push_cmd(3'd0, 7'd40, 9'd6, 4'd6);
        end_push();
        wait_cycles(4);
        @(negedge clk);
        err_clr = 1'b0;
        chk("t6_err_rise", err_rise - b_err, 1);
        chk("t6_err_cleared", int'(err_o), 0);
        chk("t6_no_issue", pen_count - b_pen, 0);

        // 7: reset during LOAD at word 10 with commands still queued
        done_delay = 1;
        b_pen = pen_count; b_done = done_count;
        push_cmd(3'd3, 7'd50, 9'd7, 4'd7);
        push_cmd(3'd1, 7'd51, 9'd8, 4'd8);
        push_cmd(3'd1, 7'd52, 9'd9, 4'd9);
        end_push();
        n = 0;
        while (!(load_en_o && load_cnt_o == 5'd10) && n < 200) begin
            wait_cycles(1);
            n++;
        end
        chk("t7_at_word10", int'(load_cnt_o), 10);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t7_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(6);
        chk("t7_level", int'(level_o), 0);
        chk("t7_busy", int'(busy_o), 0);
        chk("t7_issue_count", pen_count - b_pen, 1);
        chk("t7_no_done", done_count - b_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pim_cmd_scheduler.md
# pim_cmd_scheduler

Command scheduler between the RISC-V memory-mapped front end and the eFlash PIM datapath (row driver plus output buffer). It queues PIM commands in a small FIFO and issues them one at a time as a pim_en/mode/exec-count/address bundle. It then waits for the row driver's completion pulse and, for read and compute modes, sequences the 32-word output-buffer load. The host never drives the datapath directly, and back-to-back commands never overlap.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries (power of two, ≥2).
- TIMEOUT, 1023: max cycles in WAIT before abort.

Ports:
- clk_i  in  1  clock; one clock domain, all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  FIFO not full; a push occurs on an edge where valid&ready.
- cmd_mode_i  in  3  1=program, 2=erase, 3=read, 4=compute; 0,5,6,7 illegal.
- cmd_row_i  in  7  row address.
- cmd_col_i  in  9  column address.
- cmd_exec_i  in  4  execution count.
- pim_en_o  out  1  one-cycle issue strobe to the row driver.
- pim_mode_o  out  3  mode of the active command.
- exec_cnt_o  out  4  exec count of the active command.
- row_addr7_o  out  7  active row.
- col_addr9_o  out  9  active column.
- drv_done_i  in  1  row-driver completion pulse.
- load_en_o  out  1  output-buffer load strobe.
- load_cnt_o  out  5  output-buffer word index 0..31.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle pulse at command completion.
- err_o  out  1  sticky error flag.
- err_clr_i  in  1  clears err_o.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO: registered, first-in first-out. A push and a pop on the same edge are both performed, and the level is unchanged. cmd_ready_o = (level < DEPTH). A push while full cannot occur.
- FSM states: IDLE, ISSUE, WAIT, LOAD, DONE.
- IDLE: when level>0, pop the head, latch its fields into the output registers, and go to ISSUE. If the popped mode is illegal, set err_o, issue nothing, and stay in IDLE. The entry is discarded.
- ISSUE: pim_en_o=1 for this cycle only. Go to WAIT. drv_done_i is ignored here.
- WAIT: increment the timeout counter. On drv_done_i, go to LOAD for mode 3 or 4, otherwise go to DONE. If the counter reaches TIMEOUT with no done pulse, set err_o, go to IDLE, and do not pulse done_o.
- LOAD: load_en_o=1 with load_cnt_o = 0,1,...,31 on consecutive cycles. After index 31, go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- pim_mode_o, exec_cnt_o, row_addr7_o, and col_addr9_o hold the latched values from ISSUE through DONE. They keep those values in IDLE until the next pop.
- err_o: set has priority over err_clr_i on the same edge.
- busy_o=1 in every state except IDLE.

## Timing
- Reset values: cmd_ready_o=1, level_o=0, err_o=0, and every other output 0. The FSM is in IDLE and the FIFO is empty.
- Asserting rst_ni mid-command clears the FSM, FIFO, and counters immediately; no done_o is pulsed.
- Latency: a command pushed on edge E0 into an empty, idle scheduler gives pim_en_o high in the cycle after E1.
- Minimum per-command occupancy: 3 cycles for program/erase with drv_done_i in the first WAIT cycle, and 35 cycles for read/compute.
- Back-to-back: IDLE lasts at least one cycle between commands. pim_en_o strobes are at least 4 cycles apart.
- drv_done_i arriving outside WAIT is ignored and does not count toward the next command.
- Timeout fires on the edge where the counter equals TIMEOUT, i.e. TIMEOUT+1 WAIT cycles after entry. A drv_done_i on that same edge wins (normal completion).
- The timeout counter clears on entry to WAIT.

## Test plan
- Reset then a single program command (mode 1, row 5, col 9, exec 2), with drv_done_i 3 cycles after pim_en_o -> one pim_en_o pulse with row 5/col 9/exec 2, no load_en_o, done_o pulse, busy_o low afterwards.
- Compute command (mode 4) -> after drv_done_i, load_cnt_o steps 0..31 on consecutive cycles with load_en_o high for 32 cycles, then done_o.
- Push 5 commands back-to-back with DEPTH=4 while the first is in WAIT -> cmd_ready_o low at level 4, commands issued in push order, level_o returns to 0.
- Withhold drv_done_i -> err_o set after TIMEOUT+1 WAIT cycles, no done_o, next queued command issues. err_clr_i then clears err_o.
- Illegal mode 6 queued between two legal commands -> err_o set, no pim_en_o for it, both legal commands complete.
- Drop rst_ni during LOAD at load_cnt_o=10 -> all outputs return to reset values immediately; after release, the FIFO is empty and the scheduler is idle.
